// File: rtl/accum_arbiter_ctrl.sv
// Round-robin controller that shares one two-stage add/sub accumulator between two requesters.
// Drives acc_A / acc_add_sub at the right cycles and returns a tagged result with the flags.
module accum_arbiter_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic         req0,
    input  logic         req1,
    input  logic [1:0]   op0,
    input  logic [1:0]   op1,
    input  logic [N-1:0] data0,
    input  logic [N-1:0] data1,
    output logic         ack0,
    output logic         ack1,
    output logic         busy,
    output logic [N-1:0] acc_A,
    output logic         acc_add_sub,
    input  logic [N-1:0] acc_S,
    input  logic         acc_carry,
    input  logic         acc_overflow,
    output logic         res_valid,
    output logic         res_id,
    output logic [N-1:0] res_S,
    output logic         res_carry,
    output logic         res_overflow
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;

    // state  | meaning
    // IDLE   | accumulator held at add-0; arbitrate and grant
    // ISSUE  | operand (or S for CLR) presented on acc_A
    // EXEC   | add_sub applied; accumulator updates S and flags
    // RESULT | S and flags valid; captured on the exiting edge
    typedef enum logic [1:0] {IDLE, ISSUE, EXEC, RESULT} state_t;

    state_t         state, state_nxt;
    logic           last_grant;
    logic [1:0]     op_q;
    logic           id_q;
    logic           grant;
    logic           grant_id;
    logic [1:0]     grant_op;
    logic [N-1:0]   grant_data;
    logic [N-1:0]   acc_a_nxt;
    logic           add_sub_nxt;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        grant       = 1'b0;
        grant_id    = 1'b0;
        acc_a_nxt   = '0;
        add_sub_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant     = 1'b1;
                    grant_id  = (req0 && req1) ? ~last_grant : req1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt   = EXEC;
                add_sub_nxt = (op_q == OP_SUB) || (op_q == OP_CLR);
            end
            EXEC:    state_nxt = RESULT;
            RESULT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        grant_op   = grant_id ? op1 : op0;
        grant_data = grant_id ? data1 : data0;
        // CLR subtracts S from itself; S is stable here because idle adds 0
        if (grant) begin
            case (grant_op)
                OP_ADD, OP_SUB: acc_a_nxt = grant_data;
                OP_CLR:         acc_a_nxt = acc_S;
                default:        acc_a_nxt = '0;
            endcase
        end
    end

    assign ack0 = grant & ~grant_id & ~aclr;
    assign ack1 = grant & grant_id & ~aclr;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            last_grant   <= 1'b1;
            op_q         <= '0;
            id_q         <= 1'b0;
            acc_A        <= '0;
            acc_add_sub  <= 1'b0;
            res_valid    <= 1'b0;
            res_id       <= 1'b0;
            res_S        <= '0;
            res_carry    <= 1'b0;
            res_overflow <= 1'b0;
        end else begin
            acc_A       <= acc_a_nxt;
            acc_add_sub <= add_sub_nxt;
            res_valid   <= (state == RESULT);
            if (grant) begin
                last_grant <= grant_id;
                op_q       <= grant_op;
                id_q       <= grant_id;
            end
            if (state == RESULT) begin
                res_S        <= acc_S;
                res_carry    <= acc_carry;
                res_overflow <= acc_overflow;
                res_id       <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_accum_arbiter_ctrl.sv
// Bench for accum_arbiter_ctrl: a behavioural accumulator plant plus a transaction-level
// reference model (arithmetic on a model S, grant timing by cycle numbers).
module tb_accum_arbiter_ctrl;

    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] CLR  = 2'b10;
    localparam logic [1:0] READ = 2'b11;

    logic       clk = 1'b0;
    logic       aclr = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] op0 = '0, op1 = '0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       ack0, ack1, busy, acc_add_sub;
    logic [7:0] acc_A, acc_S, res_S;
    logic       acc_carry, acc_overflow, res_valid, res_id, res_carry, res_overflow;

    accum_arbiter_ctrl #(.N(8)) dut (
        .clk(clk), .aclr(aclr),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1), .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1), .busy(busy),
        .acc_A(acc_A), .acc_add_sub(acc_add_sub),
        .acc_S(acc_S), .acc_carry(acc_carry), .acc_overflow(acc_overflow),
        .res_valid(res_valid), .res_id(res_id), .res_S(res_S),
        .res_carry(res_carry), .res_overflow(res_overflow)
    );

    always #5 clk = ~clk;

    // Accumulator plant: A registered one cycle, then S <= S +/- A_reg every clock.
    logic [7:0] p_a, p_s, p_b;
    logic [8:0] p_sum;
    logic       p_c, p_o;
    always_comb begin
        p_b   = p_a ^ {8{acc_add_sub}};
        p_sum = {1'b0, p_s} + {1'b0, p_b} + {8'd0, acc_add_sub};
    end
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            p_a <= '0; p_s <= '0; p_c <= 1'b0; p_o <= 1'b0;
        end else begin
            p_a <= acc_A;
            p_s <= p_sum[7:0];
            p_c <= p_sum[8] ^ acc_add_sub;
            p_o <= (p_s[7] == p_b[7]) && (p_sum[7] != p_s[7]);
        end
    end
    assign acc_S        = p_s;
    assign acc_carry    = p_c;
    assign acc_overflow = p_o;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int         t = 0;
    int         g_t = -100;
    logic       m_last = 1'b1;
    logic [7:0] m_S = '0;
    bit         pend_valid = 0;
    int         pend_due = 0;
    logic [1:0] pend_op = '0;
    logic [7:0] pend_a = '0, pend_S = '0;
    logic       pend_c = 0, pend_o = 0, pend_id = 0;
    logic [7:0] held_S = '0;
    logic       held_c = 0, held_o = 0, held_id = 0;
    bit         granted [2];

    bit         s_req [2];
    logic [1:0] s_op [2];
    logic [7:0] s_data [2];

    task automatic model_reset();
        m_S = '0; m_last = 1'b1; pend_valid = 0; g_t = -100;
        held_S = '0; held_c = 0; held_o = 0; held_id = 0;
    endtask

    task automatic apply();
        req0 = s_req[0]; op0 = s_op[0]; data0 = s_data[0];
        req1 = s_req[1]; op1 = s_op[1]; data1 = s_data[1];
    endtask

    task automatic eval();
        bit   exp_rv, idle, any, w;
        int   sa, sd, r;
        logic [8:0] wide;
        apply();
        #1;
        granted[0] = 0; granted[1] = 0;
        exp_rv = pend_valid && (t == pend_due);
        chk("res_valid", res_valid, exp_rv);
        if (exp_rv) begin
            held_S = pend_S; held_c = pend_c; held_o = pend_o; held_id = pend_id;
            pend_valid = 0;
        end
        chk("res_S", res_S, held_S);
        chk("res_id", res_id, held_id);
        chk("res_carry", res_carry, held_c);
        chk("res_overflow", res_overflow, held_o);
        chk("busy", busy, (t > g_t) && (t < g_t + 4));
        chk("acc_A", acc_A, (t == g_t + 1) ? pend_a : 8'h00);
        chk("acc_add_sub", acc_add_sub,
            (t == g_t + 2) && (pend_op == SUB || pend_op == CLR));
        idle = (t >= g_t + 4);
        any  = s_req[0] || s_req[1];
        w    = (s_req[0] && s_req[1]) ? ~m_last : s_req[1];
        chk("ack0", ack0, idle && any && !w);
        chk("ack1", ack1, idle && any && w);
        if (idle && any) begin
            pend_op = s_op[w];
            pend_id = w;
            sa = int'($signed(m_S));
            sd = int'($signed(s_data[w]));
            pend_c = 0; pend_o = 0; pend_a = 8'h00;
            case (s_op[w])
                ADD: begin
                    wide   = {1'b0, m_S} + {1'b0, s_data[w]};
                    pend_S = wide[7:0];
                    pend_c = wide[8];
                    r = sa + sd;
                    pend_o = (r > 127) || (r < -128);
                    pend_a = s_data[w];
                end
                SUB: begin
                    pend_S = m_S - s_data[w];
                    pend_c = (s_data[w] > m_S);
                    r = sa - sd;
                    pend_o = (r > 127) || (r < -128);
                    pend_a = s_data[w];
                end
                CLR: begin
                    pend_S = 8'h00;
                    pend_a = m_S;
                end
                default: pend_S = m_S;
            endcase
            m_S = pend_S;
            pend_valid = 1;
            pend_due = t + 4;
            g_t = t;
            m_last = w;
            granted[w] = 1;
        end
        t++;
    endtask

    task automatic cycle();
        @(negedge clk);
        eval();
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        aclr = 1'b1;
        apply();
        #1;
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acc_A", acc_A, 0);
        chk("rst_acc_add_sub", acc_add_sub, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_S", res_S, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_flags", {res_carry, res_overflow}, 0);
        model_reset();
        repeat (hold) @(negedge clk);
        aclr = 1'b0;
        eval();
    endtask

    task automatic op_single(input int id, input logic [1:0] op, input logic [7:0] d);
        s_req[id] = 1; s_op[id] = op; s_data[id] = d;
        cycle();
        chk("single_ack", id ? ack1 : ack0, 1);
        s_req[id] = 0;
        repeat (4) cycle();
    endtask

    int ack_seq[$];

    initial begin
        s_req[0] = 0; s_req[1] = 0;
        s_op[0] = ADD; s_op[1] = ADD;
        s_data[0] = 0; s_data[1] = 0;

        // 1: single ADD
        do_reset(2);
        op_single(0, ADD, 8'h05);
        chk("t1_res", {res_id, res_S, res_carry, res_overflow}, {1'b0, 8'h05, 2'b00});

        // 2: signed overflow into 0x80
        do_reset(1);
        op_single(0, ADD, 8'h7F);
        op_single(0, ADD, 8'h01);
        chk("t2_res", {res_S, res_carry, res_overflow}, {8'h80, 2'b01});

        // 3: borrow from zero
        do_reset(1);
        op_single(1, SUB, 8'h01);
        chk("t3_res", {res_id, res_S, res_carry, res_overflow}, {1'b1, 8'hFF, 2'b10});

        // 4: both requesters held from reset alternate
        s_req[0] = 1; s_op[0] = ADD; s_data[0] = 8'h01;
        s_req[1] = 1; s_op[1] = ADD; s_data[1] = 8'h02;
        do_reset(2);
        if (ack0) ack_seq.push_back(0);
        if (ack1) ack_seq.push_back(1);
        for (int i = 0; i < 16; i++) begin
            if (i == 12) begin s_req[0] = 0; s_req[1] = 0; end
            cycle();
            if (ack0) ack_seq.push_back(0);
            if (ack1) ack_seq.push_back(1);
        end
        chk("t4_ngrants", ack_seq.size(), 4);
        for (int i = 0; i < ack_seq.size() && i < 4; i++)
            chk("t4_grant_order", ack_seq[i], i % 2);
        chk("t4_res", {res_id, res_S}, {1'b1, 8'h06});

        // 5: CLR from 0x3C, then READ
        do_reset(1);
        op_single(0, ADD, 8'h3C);
        op_single(1, CLR, 8'hA5);
        chk("t5_clr", {res_id, res_S, res_carry, res_overflow}, {1'b1, 8'h00, 2'b00});
        op_single(1, READ, 8'h77);
        chk("t5_read", res_S, 8'h00);

        // 6: abort during EXEC
        do_reset(1);
        s_req[0] = 1; s_op[0] = ADD; s_data[0] = 8'h10;
        cycle();
        s_req[0] = 0;
        cycle();
        do_reset(2);
        repeat (6) cycle();
        op_single(0, READ, 8'h00);
        chk("t6_read", {res_valid, res_S}, {1'b1, 8'h00});

        // Random traffic: holds, back-to-back requests and withdrawals
        do_reset(1);
        for (int i = 0; i < 600; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (granted[r]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        s_op[r] = 2'($urandom_range(3, 0));
                        s_data[r] = 8'($urandom);
                    end else s_req[r] = 0;
                end else if (s_req[r]) begin
                    if ($urandom_range(9, 0) == 0) s_req[r] = 0;
                end else if ($urandom_range(2, 0) == 0) begin
                    s_req[r] = 1;
                    s_op[r] = 2'($urandom_range(3, 0));
                    s_data[r] = 8'($urandom);
                end
            end
            cycle();
        end
        s_req[0] = 0; s_req[1] = 0;
        repeat (6) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accum_arbiter_ctrl.md
Name: accum_arbiter_ctrl

Overview:
Controller that shares one N-bit add/sub accumulator between two requesters and sequences each operation through its two-stage timing.
The accumulator registers operand A in one cycle, then applies add_sub in the next; it has no enable and re-accumulates every clock.
This block arbitrates round-robin and drives A and add_sub at the correct cycles. It holds the accumulator in "add 0" when idle, captures the sum and flags in the single valid cycle, and returns a tagged result.

Parameters:
N, 8, datapath width; must match the accumulator's N.

Ports:
clk  in  1  clock, rising edge
aclr  in  1  asynchronous active-high reset; same net as the accumulator's aclr
req0, req1  in  1  request from requester 0/1
op0, op1  in  2  opcode: 00 ADD, 01 SUB, 10 CLR (S<-0), 11 READ (S unchanged)
data0, data1  in  N  operand for ADD/SUB; ignored for CLR/READ
ack0, ack1  out  1  one-cycle grant pulse; op/data sampled on this cycle's edge
busy  out  1  high in any state other than IDLE
acc_A  out  N  to accumulator A input
acc_add_sub  out  1  to accumulator add_sub (1 = subtract)
acc_S  in  N  accumulator S output
acc_carry, acc_overflow  in  1  accumulator flag outputs
res_valid  out  1  one-cycle result pulse
res_id  out  1  requester that owns the result
res_S  out  N  accumulator value after the operation
res_carry, res_overflow  out  1  flags of the operation

Behaviour:
- Reset (aclr=1, async): state=IDLE; last_grant=1, so requester 0 wins first; all outputs 0, including acc_A=0 and acc_add_sub=0.
- FSM: IDLE -> ISSUE -> EXEC -> RESULT -> IDLE. Always exactly one op in flight; no pipelining.
- IDLE:
  - acc_A=0, acc_add_sub=0.
  - If any req is high, grant, pulse that ack, latch op/data/id, and go to ISSUE. Otherwise stay in IDLE.
  - With one req, that requester wins. With both, the requester not equal to last_grant wins; last_grant updates on each grant.
- ISSUE: acc_add_sub=0. acc_A is:
  - ADD/SUB: the latched data
  - CLR: current acc_S, which is stable because the idle add-0 holds it
  - READ: 0
- EXEC: acc_A=0. acc_add_sub is 1 for SUB/CLR, 0 for ADD/READ. The accumulator updates S, carry and overflow on this edge.
- RESULT:
  - acc_A=0, acc_add_sub=0.
  - On the exiting edge, load res_S<=acc_S, res_carry<=acc_carry, res_overflow<=acc_overflow, res_id<=latched id, res_valid<=1.
  - Flags are valid only in this cycle; later idle add-0 cycles overwrite them to 0.
- res_valid is high for exactly the first IDLE cycle after RESULT. A new grant may occur in that same cycle.
- res_* hold their values until the next result.
- Latency: ack in cycle 0, res_valid in cycle 4. Throughput is one op per 4 cycles under continuous requests.
- Requester handshake:
  - Hold req/op/data stable until ack.
  - req still high in the cycle after ack is a new request, eligible at the next IDLE.
  - Dropping req before ack withdraws it, with no side effects.
- Carry semantics follow the accumulator:
  - ADD: carry = carry-out.
  - SUB: carry = borrow (add_sub XOR cout).
  - overflow = signed two's-complement overflow.
- CLR result: S=0, carry=0, overflow=0.
- Arithmetic wraps modulo 2^N; the controller never saturates.
- aclr mid-operation: the FSM aborts to IDLE and the accumulator clears; the aborted op produces no res_valid; no ack is re-issued.
- acc_A and acc_add_sub are registered from state and latched data, so they are glitch-free at the accumulator inputs.

Test Plan:
1. Reset, r0 ADD 0x05 -> ack0 in cycle 0; res_valid in cycle 4 with res_id=0, res_S=0x05, carry=0, overflow=0.
2. r0 ADD 0x7F, then r0 ADD 0x01 -> second result res_S=0x80, overflow=1, carry=0.
3. From S=0, r1 SUB 0x01 -> res_S=0xFF, carry=1 (borrow), overflow=0, res_id=1.
4. req0 and req1 both held high from reset, r0 ADD 1, r1 ADD 2 -> grants alternate r0, r1, r0, r1, each ack 4 cycles apart; res_S sequence 1, 3, 4, 6.
5. With S=0x3C, r1 CLR -> res_S=0x00, carry=0, overflow=0; a following READ returns 0x00.
6. Assert aclr during EXEC of ADD 0x10 -> all outputs 0 immediately; no res_valid; after release, r0 READ returns res_S=0x00.
